// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment capture block:
// glyph patterns (GFEDCBA, active-high) and segment bit positions.
package seven_segment_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] GLYPH_0 = 7'b0111111;
  localparam logic [6:0] GLYPH_1 = 7'b0000110;
  localparam logic [6:0] GLYPH_2 = 7'b1011011;
  localparam logic [6:0] GLYPH_3 = 7'b1001111;
  localparam logic [6:0] GLYPH_4 = 7'b1100110;
  localparam logic [6:0] GLYPH_5 = 7'b1101101;
  localparam logic [6:0] GLYPH_6 = 7'b1111101;
  localparam logic [6:0] GLYPH_7 = 7'b0000111;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1101111;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b1111100;
  localparam logic [6:0] GLYPH_C = 7'b0111001;
  localparam logic [6:0] GLYPH_D = 7'b1011110;
  localparam logic [6:0] GLYPH_E = 7'b1111001;
  localparam logic [6:0] GLYPH_F = 7'b1110001;
  // Older driver firmware lights only segment E for a 9.
  localparam logic [6:0] GLYPH_9_ALT = 7'b0010000;

endpackage

// File: rtl/seven_segment_pattern_decoder.sv
// Maps a lit-segment pattern back to its hex value.
// Anything outside the glyph table, blank included, is unrecognised.
module seven_segment_pattern_decoder
  import seven_segment_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       recognised,
  output logic [3:0] value
);

  always_comb begin
    recognised = 1'b1;
    value      = 4'h0;
    unique case (1'b1)
      (pattern == GLYPH_0):     value = 4'h0;
      (pattern == GLYPH_1):     value = 4'h1;
      (pattern == GLYPH_2):     value = 4'h2;
      (pattern == GLYPH_3):     value = 4'h3;
      (pattern == GLYPH_4):     value = 4'h4;
      (pattern == GLYPH_5):     value = 4'h5;
      (pattern == GLYPH_6):     value = 4'h6;
      (pattern == GLYPH_7):     value = 4'h7;
      (pattern == GLYPH_8):     value = 4'h8;
      (pattern == GLYPH_9):     value = 4'h9;
      (pattern == GLYPH_9_ALT): value = 4'h9;
      (pattern == GLYPH_A):     value = 4'hA;
      (pattern == GLYPH_B):     value = 4'hB;
      (pattern == GLYPH_C):     value = 4'hC;
      (pattern == GLYPH_D):     value = 4'hD;
      (pattern == GLYPH_E):     value = 4'hE;
      (pattern == GLYPH_F):     value = 4'hF;
      default:                  recognised = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Samples a multiplexed seven-segment bus and holds one decoded
// register per digit once each slot has been stable long enough.
module seven_segment_capture
  import seven_segment_pkg::*;
#(
  parameter int SEL_BITS      = 1,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   segments,
  input  logic [SEL_BITS-1:0]          sel,
  output logic [4*(1<<SEL_BITS)-1:0]   code,
  output logic [(1<<SEL_BITS)-1:0]     points,
  output logic [(1<<SEL_BITS)-1:0]     digit_valid,
  output logic                         frame_done,
  output logic                         pattern_error
);

  localparam int N  = 1 << SEL_BITS;
  localparam int W  = SEL_BITS + 8;
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [W-1:0]  s1, s2, s3;
  logic [2:0]    primed;
  logic [CW-1:0] cnt;
  logic [N-1:0]  seen;
  logic          capture;
  logic          recognised;
  logic [3:0]    value;
  logic [SEL_BITS-1:0] cap_sel;
  logic [N-1:0]  hit;

  assign cap_sel = s3[W-1:8];
  assign hit     = N'(1) << cap_sel;

  // s3 only compares meaningfully once a real sample has reached it,
  // so reset zeros never count as a stable slot.
  assign capture = primed[2] && (s2 == s3)
                 && (cnt == CW'(STABLE_CYCLES - 1));

  seven_segment_pattern_decoder u_dec (
    .pattern    (s3[6:0]),
    .recognised (recognised),
    .value      (value)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      s3     <= '0;
      primed <= '0;
      cnt    <= '0;
    end else begin
      s1     <= {sel, segments};
      s2     <= s1;
      s3     <= s2;
      primed <= {primed[1:0], 1'b1};
      if (!primed[2] || (s2 != s3))
        cnt <= '0;
      else if (cnt != CW'(STABLE_CYCLES))
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code          <= '0;
      points        <= '0;
      digit_valid   <= '0;
      seen          <= '0;
      frame_done    <= 1'b0;
      pattern_error <= 1'b0;
    end else begin
      frame_done    <= 1'b0;
      pattern_error <= 1'b0;
      if (capture) begin
        points[cap_sel] <= ~s3[SEG_DP];
        if (recognised) begin
          code[4*int'(cap_sel) +: 4] <= value;
          digit_valid[cap_sel]       <= 1'b1;
        end else begin
          digit_valid[cap_sel] <= 1'b0;
          pattern_error        <= 1'b1;
        end
        if ((seen | hit) == {N{1'b1}}) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen <= seen | hit;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Scoreboard bench for seven_segment_capture with two digits
// and an eight-sample dwell.
module tb_seven_segment_capture;

  localparam int S = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] seg_i;
  logic [0:0] sel_i;
  logic [7:0] code;
  logic [1:0] points;
  logic [1:0] digit_valid;
  logic       frame_done;
  logic       pattern_error;

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  int pe_cnt = 0;
  int v0_rise = 0;
  logic v0_prev = 1'b0;

  typedef struct {
    int         sel;
    logic [3:0] code;
    logic       valid;
    logic       pt;
    int         fd;
    int         pe;
  } exp_t;

  exp_t sb[$];

  logic [3:0] m_code [2];
  logic [1:0] m_valid;
  logic [1:0] m_pts;
  logic [1:0] m_seen;
  logic [8:0] last_in;

  seven_segment_capture #(
    .SEL_BITS      (1),
    .STABLE_CYCLES (S)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .segments      (seg_i),
    .sel           (sel_i),
    .code          (code),
    .points        (points),
    .digit_valid   (digit_valid),
    .frame_done    (frame_done),
    .pattern_error (pattern_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (frame_done) fd_cnt++;
    if (pattern_error) pe_cnt++;
    if (digit_valid[0] && !v0_prev) v0_rise++;
    v0_prev = digit_valid[0];
  end

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    case (p)
      7'h3F: return 5'h10;
      7'h06: return 5'h11;
      7'h5B: return 5'h12;
      7'h4F: return 5'h13;
      7'h66: return 5'h14;
      7'h6D: return 5'h15;
      7'h7D: return 5'h16;
      7'h07: return 5'h17;
      7'h7F: return 5'h18;
      7'h6F: return 5'h19;
      7'h10: return 5'h19;
      7'h77: return 5'h1A;
      7'h7C: return 5'h1B;
      7'h39: return 5'h1C;
      7'h5E: return 5'h1D;
      7'h79: return 5'h1E;
      7'h71: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  task automatic drive_slot(input int s, input logic [7:0] seg,
                            input int cyc);
    exp_t e;
    logic [4:0] d;
    int fd0;
    int pe0;
    logic [3:0] got_code;
    e.fd = 0;
    e.pe = 0;
    if ({s[0], seg} != last_in && cyc >= S + 3) begin
      d = ref_decode(seg[6:0]);
      m_pts[s] = ~seg[7];
      if (d[4]) begin
        m_code[s]  = d[3:0];
        m_valid[s] = 1'b1;
      end else begin
        m_valid[s] = 1'b0;
        e.pe = 1;
      end
      m_seen[s] = 1'b1;
      if (m_seen == 2'b11) begin
        e.fd = 1;
        m_seen = 2'b00;
      end
    end
    last_in = {s[0], seg};
    e.sel = s;
    e.code = m_code[s];
    e.valid = m_valid[s];
    e.pt = m_pts[s];
    sb.push_back(e);
    fd0 = fd_cnt;
    pe0 = pe_cnt;
    sel_i = s[0];
    seg_i = seg;
    repeat (cyc) @(negedge clk);
    e = sb.pop_front();
    got_code = code[4*e.sel +: 4];
    checks++;
    if (got_code !== e.code) begin
      failures++;
      $display("FAIL slot_code sel=%0d got=%h exp=%h",
               e.sel, got_code, e.code);
    end
    checks++;
    if (digit_valid[e.sel] !== e.valid) begin
      failures++;
      $display("FAIL slot_valid sel=%0d got=%b exp=%b",
               e.sel, digit_valid[e.sel], e.valid);
    end
    checks++;
    if (points[e.sel] !== e.pt) begin
      failures++;
      $display("FAIL slot_point sel=%0d got=%b exp=%b",
               e.sel, points[e.sel], e.pt);
    end
    checks++;
    if (fd_cnt - fd0 != e.fd) begin
      failures++;
      $display("FAIL slot_frame_done sel=%0d got=%0d exp=%0d",
               e.sel, fd_cnt - fd0, e.fd);
    end
    checks++;
    if (pe_cnt - pe0 != e.pe) begin
      failures++;
      $display("FAIL slot_pattern_error sel=%0d got=%0d exp=%0d",
               e.sel, pe_cnt - pe0, e.pe);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    sel_i = 1'b0;
    seg_i = 8'h5B;
    repeat (3) @(negedge clk);
    checks++;
    if ({code, points, digit_valid, frame_done, pattern_error} !== 14'h0)
    begin
      failures++;
      $display("FAIL reset_outputs got code=%h pts=%b vld=%b fd=%b pe=%b exp all 0",
               code, points, digit_valid, frame_done, pattern_error);
    end
  endtask

  task automatic test_latency;
    reset = 1'b0;
    repeat (S + 2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (digit_valid !== 2'b00) begin
      failures++;
      $display("FAIL latency_early got=%b exp=00", digit_valid);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (digit_valid !== 2'b01) begin
      failures++;
      $display("FAIL latency_valid got=%b exp=01", digit_valid);
    end
    checks++;
    if (code[3:0] !== 4'h2) begin
      failures++;
      $display("FAIL latency_code got=%h exp=2", code[3:0]);
    end
    checks++;
    if (points !== 2'b01) begin
      failures++;
      $display("FAIL latency_points got=%b exp=01", points);
    end
    checks++;
    if (fd_cnt != 0) begin
      failures++;
      $display("FAIL latency_frame_done got=%0d exp=0", fd_cnt);
    end
    m_code[0] = 4'h2;
    m_code[1] = 4'h0;
    m_valid = 2'b01;
    m_pts = 2'b01;
    m_seen = 2'b01;
    last_in = {1'b0, 8'h5B};
    repeat (S) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 2; i++) begin
      drive_slot(0, 8'h06, 16);
      drive_slot(1, 8'h7F, 16);
    end
    checks++;
    if (code !== 8'h81) begin
      failures++;
      $display("FAIL alternate_code got=%h exp=81", code);
    end
  endtask

  task automatic test_alias;
    drive_slot(1, 8'h10, 16);
  endtask

  task automatic test_blank;
    drive_slot(0, 8'h4F, 16);
    drive_slot(0, 8'h80, 16);
  endtask

  task automatic test_glitch;
    int r0;
    int fd0;
    int pe0;
    logic zero_seen;
    r0 = v0_rise;
    fd0 = fd_cnt;
    pe0 = pe_cnt;
    zero_seen = 1'b0;
    sel_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      seg_i = (i >= 3 && i < 8) ? 8'h3F : 8'h4F;
      @(negedge clk);
      if (code[3:0] == 4'h0) zero_seen = 1'b1;
    end
    checks++;
    if (zero_seen !== 1'b0) begin
      failures++;
      $display("FAIL glitch_no_zero got=%b exp=0", zero_seen);
    end
    checks++;
    if (v0_rise - r0 != 1) begin
      failures++;
      $display("FAIL glitch_captures got=%0d exp=1", v0_rise - r0);
    end
    checks++;
    if (code[3:0] !== 4'h3 || digit_valid[0] !== 1'b1) begin
      failures++;
      $display("FAIL glitch_final got code=%h vld=%b exp code=3 vld=1",
               code[3:0], digit_valid[0]);
    end
    checks++;
    if (fd_cnt - fd0 != 0 || pe_cnt - pe0 != 0) begin
      failures++;
      $display("FAIL glitch_pulses got fd=%0d pe=%0d exp 0 0",
               fd_cnt - fd0, pe_cnt - pe0);
    end
    m_code[0] = 4'h3;
    m_valid[0] = 1'b1;
    m_pts[0] = 1'b1;
    last_in = {1'b0, 8'h4F};
  endtask

  task automatic test_reset_mid;
    int pe0;
    sel_i = 1'b1;
    seg_i = 8'h06;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({code, points, digit_valid, frame_done, pattern_error} !== 14'h0)
    begin
      failures++;
      $display("FAIL reset_mid_outputs got code=%h pts=%b vld=%b exp all 0",
               code, points, digit_valid);
    end
    pe0 = pe_cnt;
    reset = 1'b0;
    repeat (S + 2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (digit_valid !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_early got=%b exp=00", digit_valid);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (digit_valid !== 2'b10 || code !== 8'h10 || points !== 2'b10) begin
      failures++;
      $display("FAIL reset_mid_capture got vld=%b code=%h pts=%b exp 10 10 10",
               digit_valid, code, points);
    end
    checks++;
    if (pe_cnt - pe0 != 0) begin
      failures++;
      $display("FAIL reset_mid_error got=%0d exp=0", pe_cnt - pe0);
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_back_to_back;
    test_alias;
    test_blank;
    test_glitch;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
